sparse_result_writer: RTL

SPARSE_RESULT_WRITER -- requirements
Module: sparse_result_writer

---
 rtl/sparse_pkg.sv | 24 ++
 rtl/sparse_result_writer_if.sv | 27 ++
 rtl/sparse_entry_fifo.sv | 54 +++++
 rtl/sparse_result_writer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/sparse_pkg.sv
// Shared types for the sparse result writer: FIFO entry, FSM state encoding, default sizes.
// SPARSE_ZERO_FILL_EN adds the FILL state used to zero-fill skipped rows.
package sparse_pkg;

  localparam int N_ROWS_DEF = 560;
  localparam int N_COLS_DEF = 560;

  typedef struct packed {
    logic        pair_valid;
    logic        zero_after;
    logic [63:0] data_odd;
    logic [63:0] data_even;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
`ifdef SPARSE_ZERO_FILL_EN
    ST_FILL  = 2'd2,
`endif
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sparse_result_writer_if.sv
// Result-pair input stream and memory write bus of the sparse result writer.
interface sparse_result_writer_if;

  logic [63:0]  dataout1;
  logic [63:0]  dataout2;
  logic         valid;
  logic         zeros;
  logic         wr_en;
  logic [9:0]   wr_row;
  logic [9:0]   wr_col;
  logic [127:0] wr_data;
  logic         wr_ready;
  logic         done;
  logic         overflow;
  logic         misalign;

  modport master (
    output dataout1, dataout2, valid, zeros, wr_ready,
    input  wr_en, wr_row, wr_col, wr_data, done, overflow, misalign
  );

  modport slave (
    input  dataout1, dataout2, valid, zeros, wr_ready,
    output wr_en, wr_row, wr_col, wr_data, done, overflow, misalign
  );

endinterface

// File: rtl/sparse_entry_fifo.sv
// Synchronous entry FIFO; the head entry is read straight from storage flops.
// DEPTH must be a power of two, at least 2.
module sparse_entry_fifo
  import sparse_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  entry_t wr_entry,
  output entry_t rd_entry,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  entry_t      mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when indices match.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
  end

endmodule

// File: rtl/sparse_result_writer.sv
// Writes multiplier result pairs into the result matrix, tracking row/column and row skips.
// SPARSE_ZERO_FILL_EN: skipped rows are written with zeros instead of just being stepped over.
module sparse_result_writer
  import sparse_pkg::*;
#(
  parameter int N_ROWS     = N_ROWS_DEF,
  parameter int N_COLS     = N_COLS_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input logic                   clk,
  input logic                   rst,
  sparse_result_writer_if.slave bus
);

  localparam logic [9:0] LAST_COL = 10'(N_COLS - 2);
  localparam logic [9:0] ROW_END  = 10'(N_ROWS);

  state_e     state_q, state_d;
  logic [9:0] row_q, row_d;
  logic [9:0] col_q, col_d;
  logic       overflow_q, overflow_d;
  logic       misalign_q, misalign_d;
  logic       push, pop, full, empty;
  entry_t     in_entry, head;
  logic       apply_zero;
  logic [9:0] row_nx, col_nx;

  assign push     = (bus.valid || bus.zeros) && (state_q != ST_DONE);
  assign in_entry = '{pair_valid: bus.valid, zero_after: bus.zeros,
                      data_odd: bus.dataout2, data_even: bus.dataout1};

  sparse_entry_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .wr_entry (in_entry),
    .rd_entry (head),
    .full     (full),
    .empty    (empty)
  );

  // The head entry stays in the FIFO until its pair is accepted, so it counts toward depth.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    overflow_d = overflow_q;
    misalign_d = misalign_q;
    pop        = 1'b0;
    apply_zero = 1'b0;
    row_nx     = row_q;
    col_nx     = col_q;

    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          if (head.pair_valid) begin
            state_d = ST_WRITE;
          end else begin
            pop        = 1'b1;
            apply_zero = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (bus.wr_ready) begin
          pop = 1'b1;
          if (col_q == LAST_COL) begin
            row_nx = row_q + 10'd1;
            col_nx = '0;
          end else begin
            col_nx = col_q + 10'd2;
          end
          row_d = row_nx;
          col_d = col_nx;
          if (row_nx == ROW_END)    state_d = ST_DONE;
          else if (head.zero_after) apply_zero = 1'b1;
          else                      state_d = ST_IDLE;
        end
      end
`ifdef SPARSE_ZERO_FILL_EN
      ST_FILL: begin
        if (bus.wr_ready) begin
          if (col_q == LAST_COL) begin
            col_d   = '0;
            row_d   = row_q + 10'd1;
            state_d = (row_q + 10'd1 == ROW_END) ? ST_DONE : ST_IDLE;
          end else begin
            col_d = col_q + 10'd2;
          end
        end
      end
`endif
      default: ;
    endcase

    // Row skip is applied to the position left behind by the pair (if any).
    if (apply_zero) begin
      if (col_nx != '0) misalign_d = 1'b1;
      col_d = '0;
`ifdef SPARSE_ZERO_FILL_EN
      row_d   = row_nx;
      state_d = ST_FILL;
`else
      row_d   = row_nx + 10'd1;
      state_d = (row_nx + 10'd1 == ROW_END) ? ST_DONE : ST_IDLE;
`endif
    end

    if (push && full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      overflow_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      overflow_q <= overflow_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef SPARSE_ZERO_FILL_EN
  assign bus.wr_en = (state_q == ST_WRITE) || (state_q == ST_FILL);
`else
  assign bus.wr_en = (state_q == ST_WRITE);
`endif
  assign bus.wr_row   = row_q;
  assign bus.wr_col   = col_q;
  assign bus.wr_data  = (state_q == ST_WRITE) ? {head.data_odd, head.data_even} : '0;
  assign bus.done     = (state_q == ST_DONE);
  assign bus.overflow = overflow_q;
  assign bus.misalign = misalign_q;

endmodule
